rs232c_tx_buffer: RTL and testbench

//  Transmit side of the RS232C path: accepts byte pushes from the OUTPUTB dispatch stage
//  (push_send_data/send_data), buffers them in a FIFO and serialises them onto the UART TX line.

---
 rtl/rs232c_pkg.sv | 22 ++
 rtl/rs232c_fifo.sv | 55 +++++
 rtl/rs232c_tx_buffer.sv | 120 ++++++++++++
 tb/tb_rs232c_tx_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rs232c_pkg.sv
// Shared RS232C definitions: transmit FSM state type, frame length
// and default bit period. Build option: RS232C_TX_PARITY_EN.
package rs232c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

`ifdef RS232C_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // 100 MHz / 115200 baud
  localparam logic [15:0] WTIME_DEFAULT = 16'd868;

endpackage

// File: rtl/rs232c_fifo.sv
// Synchronous FIFO with registered occupancy count.
// Ports: clk, rst_n, push/wr_data, pop/rd_data (head, comb), full, empty.
module rs232c_fifo
  import rs232c_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rs232c_tx_buffer.sv
// Buffered RS232C transmitter: FIFO + 8N1 serialiser (8E1 with RS232C_TX_PARITY_EN).
// Ports: clk, rst_n, push_send_data/send_data in; tx, full, busy, dropped out.
module rs232c_tx_buffer
  import rs232c_pkg::*;
#(
  parameter logic [15:0] WTIME      = WTIME_DEFAULT,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_send_data,
  input  logic [7:0] send_data,
  output logic       tx,
  output logic       full,
  output logic       busy,
  output logic       dropped
);

  tx_state_t   state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        tx_q;
  logic [7:0]  head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        baud_end;
  logic        pop;
`ifdef RS232C_TX_PARITY_EN
  logic        par_q;
`endif

  rs232c_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_send_data),
    .wr_data (send_data),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign baud_end = (baud_cnt == 16'd0);

  // Pop from idle, or at the end of a stop bit for gapless frames
  assign pop = ~fifo_empty &
               ((state == ST_IDLE) |
                ((state == ST_STOP) & baud_end));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
      dropped  <= 1'b0;
`ifdef RS232C_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      if (push_send_data && fifo_full) dropped <= 1'b1;
      if (pop) begin
        shift    <= head;
        baud_cnt <= WTIME - 16'd1;
        bit_cnt  <= '0;
        tx_q     <= 1'b0;
        state    <= ST_START;
`ifdef RS232C_TX_PARITY_EN
        par_q    <= ^head;
`endif
      end else if (state == ST_IDLE) begin
        tx_q <= 1'b1;
      end else if (!baud_end) begin
        baud_cnt <= baud_cnt - 16'd1;
      end else begin
        baud_cnt <= WTIME - 16'd1;
        case (state)
          ST_START: begin
            state <= ST_DATA;
            tx_q  <= shift[0];
            shift <= shift >> 1;
          end
          ST_DATA: begin
            if (bit_cnt == 3'd7) begin
`ifdef RS232C_TX_PARITY_EN
              state <= ST_PARITY;
              tx_q  <= par_q;
`else
              state <= ST_STOP;
              tx_q  <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_q    <= shift[0];
              shift   <= shift >> 1;
            end
          end
          ST_PARITY: begin
            state <= ST_STOP;
            tx_q  <= 1'b1;
          end
          default: begin
            state <= ST_IDLE;
            tx_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx   = tx_q;
  assign full = fifo_full;
  assign busy = (state != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_rs232c_tx_buffer.sv
// Directed bench for rs232c_tx_buffer (WTIME=4, DEPTH_LOG2=2).
// Logs tx/busy every negedge and decodes frames at mid-bit.
module tb_rs232c_tx_buffer;
  import rs232c_pkg::*;

  localparam logic [15:0] WT = 16'd4;
  localparam int DL = 2;
  localparam int FL = FRAME_BITS * 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push_send_data;
  logic [7:0] send_data;
  logic       tx;
  logic       full;
  logic       busy;
  logic       dropped;

  always #5 clk = ~clk;

  rs232c_tx_buffer #(
    .WTIME      (WT),
    .DEPTH_LOG2 (DL)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .push_send_data (push_send_data),
    .send_data      (send_data),
    .tx             (tx),
    .full           (full),
    .busy           (busy),
    .dropped        (dropped)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic txl [0:4095];
  logic bl  [0:4095];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    txl[cyc] = tx;
    bl[cyc]  = busy;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    push_send_data = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic push_byte(input logic [7:0] b, output int s);
    push_send_data = 1'b1;
    send_data = b;
    step();
    s = cyc;
    push_send_data = 1'b0;
  endtask

  function automatic logic [10:0] exp_frame(input logic [7:0] b);
`ifdef RS232C_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b0, 1'b1, b, 1'b0};
`endif
  endfunction

  function automatic logic [10:0] got_frame(input int st);
    logic [10:0] v;
    v = '0;
    for (int k = 0; k < FRAME_BITS; k++) v[k] = txl[st + 4*k + 2];
    return v;
  endfunction

  logic [7:0] b3 [6];
  logic [7:0] b4 [5];
  int s;
  int lows;

  initial begin
    b3[0] = 8'h11; b3[1] = 8'h22; b3[2] = 8'h33;
    b3[3] = 8'h44; b3[4] = 8'h55; b3[5] = 8'h66;
    b4[0] = 8'hA1; b4[1] = 8'hB2; b4[2] = 8'hC3;
    b4[3] = 8'hD4; b4[4] = 8'hE5;
    rst_n = 1'b0;
    push_send_data = 1'b0;
    send_data = 8'h00;
    steps(3);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_dropped", dropped, 0);
    rst_n = 1'b1;
    step();

    // single frame
    push_byte(8'hA5, s);
    chk("t1_tx_pre", txl[s], 1);
    chk("t1_busy", bl[s], 1);
    steps(FL + 2);
    chk("t1_start", txl[s+1], 0);
    chk("t1_frame", got_frame(s+1), exp_frame(8'hA5));
    chk("t1_busy_last", bl[s+FL], 1);
    chk("t1_busy_end", bl[s+FL+1], 0);

    // back-to-back
    push_send_data = 1'b1;
    send_data = 8'h00;
    step();
    s = cyc;
    send_data = 8'hFF;
    step();
    push_send_data = 1'b0;
    steps(2*FL + 2);
    chk("t2_frame0", got_frame(s+1), exp_frame(8'h00));
    chk("t2_frame1", got_frame(s+1+FL), exp_frame(8'hFF));
    chk("t2_nogap", txl[s+FL+1], 0);
    chk("t2_busy_last", bl[s+2*FL], 1);
    chk("t2_busy_end", bl[s+2*FL+1], 0);

    // overflow
    push_send_data = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_data = b3[i];
      step();
      if (i == 0) s = cyc;
      if (i == 3) chk("t3_not_full", full, 0);
      if (i == 4) chk("t3_full", full, 1);
    end
    push_send_data = 1'b0;
    chk("t3_dropped", dropped, 1);
    steps(5*FL + 2);
    for (int j = 0; j < 5; j++)
      chk($sformatf("t3_frame%0d", j),
          got_frame(s+1+j*FL), exp_frame(b3[j]));
    chk("t3_sticky", dropped, 1);
    chk("t3_busy_end", bl[s+5*FL+1], 0);

    // push while full on the pop edge
    do_reset();
    push_send_data = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_data = b4[i];
      step();
      if (i == 0) s = cyc;
    end
    push_send_data = 1'b0;
    steps(FL - 4);
    chk("t4_full_pre", full, 1);
    chk("t4_drop_pre", dropped, 0);
    push_send_data = 1'b1;
    send_data = 8'hEE;
    step();
    push_send_data = 1'b0;
    chk("t4_full_post", full, 0);
    chk("t4_dropped", dropped, 1);
    chk("t4_count", dut.u_fifo.count, 3);
    steps(4*FL + 1);
    for (int j = 0; j < 5; j++)
      chk($sformatf("t4_frame%0d", j),
          got_frame(s+1+j*FL), exp_frame(b4[j]));
    chk("t4_no_extra", bl[s+5*FL+1], 0);

    // reset mid-frame
    do_reset();
    push_send_data = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_data = (i == 0) ? 8'h3C : 8'h5A;
      step();
      if (i == 0) s = cyc;
    end
    push_send_data = 1'b0;
    steps(13);
    chk("t5_bit3", txl[s+18], 1);
    chk("t5_bit1", txl[s+10], 0);
    chk("t5_full_pre", full, 1);
    chk("t5_drop_pre", dropped, 1);
    rst_n = 1'b0;
    step();
    chk("t5_tx", tx, 1);
    chk("t5_busy", busy, 0);
    chk("t5_full", full, 0);
    chk("t5_dropped", dropped, 0);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 3*FL; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("t5_quiet", lows, 0);

    // parity bytes
    push_byte(8'h07, s);
    steps(FL + 2);
    chk("t6_frame07", got_frame(s+1), exp_frame(8'h07));
    chk("t6_len07", {bl[s+FL], bl[s+FL+1]}, 2'b10);
`ifdef RS232C_TX_PARITY_EN
    chk("t6_par07", txl[s+1+4*9+2], 1);
`endif
    push_byte(8'h03, s);
    steps(FL + 2);
    chk("t6_frame03", got_frame(s+1), exp_frame(8'h03));
    chk("t6_len03", {bl[s+FL], bl[s+FL+1]}, 2'b10);
`ifdef RS232C_TX_PARITY_EN
    chk("t6_par03", txl[s+1+4*9+2], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
